keyed_propagation_lock: RTL and testbench

KEYED_PROPAGATION_LOCK -- requirements
Module: keyed_propagation_lock

---
 rtl/keyed_lock_pkg.sv | 39 +++
 rtl/key_loader.sv | 122 ++++++++++++
 rtl/keyed_propagation_lock.sv | 111 +++++++++++
 tb/tb_keyed_propagation_lock.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keyed_lock_pkg.sv
// ---------------------------------------------------------------------------
// keyed_lock_pkg
//   Shared types and helpers for the keyed propagation lock.
//
//   Contents:
//     lock_state_t : key loader FSM state encoding
//     MAX_KEY_W    : widest key the slice helper can handle
//     key_slice()  : extracts slice idx (width bits) from a key vector
//
//   Configuration macro: KEY_PARITY_EN adds the PARITY and ERR states.
// ---------------------------------------------------------------------------
package keyed_lock_pkg;

    // key_slice() works on a fixed-width container, so WIDTH must stay
    // below MAX_KEY_W / 3.
    localparam int MAX_KEY_W = 64;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ARMED  = 2'd1
`ifdef KEY_PARITY_EN
        ,
        PARITY = 2'd2,
        ERR    = 2'd3
`endif
    } lock_state_t;

    // Returns key[idx*width +: width], zero-extended to MAX_KEY_W bits.
    function automatic logic [MAX_KEY_W-1:0] key_slice(
        input logic [MAX_KEY_W-1:0] key,
        input int                   idx,
        input int                   width
    );
        logic [MAX_KEY_W-1:0] mask;
        mask = (MAX_KEY_W'(1) << width) - MAX_KEY_W'(1);
        return (key >> (idx * width)) & mask;
    endfunction

endpackage

// File: rtl/key_loader.sv
// ---------------------------------------------------------------------------
// key_loader
//   Serial key receiver and lock FSM. Bits arrive LSB first over a
//   valid/ready handshake; once KEY_W bits are in (and, with
//   KEY_PARITY_EN, a matching parity bit) the lock is ARMED and the
//   stored key is presented as the effective key. In every other state
//   the effective key is all zeros.
//
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     i_key_valid       : serial key bit offered
//     i_key_bit         : serial key bit value
//     o_key_ready       : loader accepts a key bit (LOAD / PARITY)
//     i_key_reload      : discard key and restart loading
//     o_key_done        : lock is ARMED
//     o_key_err         : parity failure (ERR); constant 0 without macro
//     o_eff_key[KEY_W]  : effective key fed to the datapath
//
//   Configuration macro: KEY_PARITY_EN enables the parity bit check.
// ---------------------------------------------------------------------------
module key_loader
    import keyed_lock_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int KEY_W = 3 * WIDTH,
    localparam int CNT_W = $clog2(KEY_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_key_valid,
    input  logic             i_key_bit,
    output logic             o_key_ready,
    input  logic             i_key_reload,
    output logic             o_key_done,
    output logic             o_key_err,
    output logic [KEY_W-1:0] o_eff_key
);

    lock_state_t      r_state;
    lock_state_t      w_state_next;
    logic [KEY_W-1:0] r_key;
    logic [KEY_W-1:0] w_key_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the key register is reset explicitly because a reset
            // mid-load must discard partial keys; it is not a memory array.
            r_state <= LOAD;
            r_key   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_key   <= w_key_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_next = r_state;
        w_key_next   = r_key;
        w_cnt_next   = r_cnt;
        o_key_ready  = 1'b0;
        o_key_done   = 1'b0;
        o_key_err    = 1'b0;

        case (r_state)
            LOAD: begin
                o_key_ready = 1'b1;
                if (i_key_valid) begin
                    w_key_next[r_cnt] = i_key_bit;
                    w_cnt_next        = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(KEY_W - 1)) begin
`ifdef KEY_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = ARMED;
`endif
                    end
                end
            end
`ifdef KEY_PARITY_EN
            PARITY: begin
                o_key_ready = 1'b1;
                if (i_key_valid) begin
                    if (i_key_bit == ^r_key) begin
                        w_state_next = ARMED;
                    end else begin
                        w_key_next   = '0;
                        w_state_next = ERR;
                    end
                end
            end
            ERR: begin
                o_key_err = 1'b1;
            end
`endif
            ARMED: begin
                o_key_done = 1'b1;
            end
            default: begin
                w_state_next = LOAD;
            end
        endcase

        // Reload overrides whatever the state decided, including a key bit
        // offered in the same cycle.
        if (i_key_reload) begin
            w_key_next   = '0;
            w_cnt_next   = '0;
            w_state_next = LOAD;
        end
    end

    assign o_eff_key = (r_state == ARMED) ? r_key : '0;

endmodule

// File: rtl/keyed_propagation_lock.sv
// ---------------------------------------------------------------------------
// keyed_propagation_lock
//   Two-stage bitwise datapath gated by a serially loaded key. Without a
//   valid key (not ARMED) the effective key is zero and both results are 0.
//     w2   = ~in2 ^ k1
//     out1 = (in1 & w2) & k0
//     out2 = (w2 & in3) & k2
//   Latency 2 cycles, throughput 1 per cycle, no backpressure.
//
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     key_valid, key_bit       : serial key input (LSB first)
//     key_ready                : key bit accepted when key_valid & key_ready
//     key_reload               : discard key and restart loading
//     key_done                 : lock ARMED
//     key_err                  : parity failure (0 without KEY_PARITY_EN)
//     in_valid, in1, in2, in3  : data operands
//     out_valid, out1, out2    : locked results
//
//   Configuration macro: KEY_PARITY_EN (parity bit after the key).
// ---------------------------------------------------------------------------
module keyed_propagation_lock
    import keyed_lock_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int KEY_W = 3 * WIDTH,
    localparam int CNT_W = $clog2(KEY_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic             key_bit,
    output logic             key_ready,
    input  logic             key_reload,
    output logic             key_done,
    output logic             key_err,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic             out_valid,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2
);

    logic [KEY_W-1:0] w_eff_key;
    logic [WIDTH-1:0] w_k0, w_k1, w_k2;
    logic [WIDTH-1:0] w_w2, w_out1, w_out2;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_in1, r_in2, r_in3;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out1, r_out2;

    key_loader #(.WIDTH(WIDTH)) u_loader (
        .clk          (clk),
        .rst          (rst),
        .i_key_valid  (key_valid),
        .i_key_bit    (key_bit),
        .o_key_ready  (key_ready),
        .i_key_reload (key_reload),
        .o_key_done   (key_done),
        .o_key_err    (key_err),
        .o_eff_key    (w_eff_key)
    );

    assign w_k0 = WIDTH'(key_slice(MAX_KEY_W'(w_eff_key), 0, WIDTH));
    assign w_k1 = WIDTH'(key_slice(MAX_KEY_W'(w_eff_key), 1, WIDTH));
    assign w_k2 = WIDTH'(key_slice(MAX_KEY_W'(w_eff_key), 2, WIDTH));

    // Stage 2 uses the key of the cycle it computes in, so a sample in
    // flight when the lock leaves ARMED is processed with the zero key.
    assign w_w2   = ~r_in2 ^ w_k1;
    assign w_out1 = (r_in1 & w_w2) & w_k0;
    assign w_out2 = (w_w2 & r_in3) & w_k2;

    // Stage 1: capture operands every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_in1      <= '0;
            r_in2      <= '0;
            r_in3      <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_in1      <= in1;
            r_in2      <= in2;
            r_in3      <= in3;
        end
    end

    // Stage 2: results only update on valid samples; otherwise they hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out1      <= '0;
            r_out2      <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out1 <= w_out1;
                r_out2 <= w_out2;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out1      = r_out1;
    assign out2      = r_out2;

endmodule

// File: tb/tb_keyed_propagation_lock.sv
// ---------------------------------------------------------------------------
// tb_keyed_propagation_lock
//   Directed, self-checking bench for keyed_propagation_lock (WIDTH=4).
//   Expected results come from a reference model of the datapath and are
//   queued when a sample is driven; they are popped when out_valid rises
//   and the arrival cycle is checked against the 2-cycle latency.
//   Build with KEY_PARITY_EN defined to exercise the parity path.
// ---------------------------------------------------------------------------
module tb_keyed_propagation_lock;

    localparam int WIDTH = 4;
    localparam int KEY_W = 3 * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             key_valid, key_bit, key_ready, key_reload;
    logic             key_done, key_err;
    logic             in_valid;
    logic [WIDTH-1:0] in1, in2, in3;
    logic             out_valid;
    logic [WIDTH-1:0] out1, out2;

    typedef struct {
        int             due;
        logic [WIDTH-1:0] o1;
        logic [WIDTH-1:0] o2;
    } exp_t;

    exp_t             q[$];
    int               checks = 0;
    int               errors = 0;
    int               cycle  = 0;
    logic [WIDTH-1:0] last1  = '0;
    logic [WIDTH-1:0] last2  = '0;
    logic [KEY_W-1:0] model_key = '0;

    keyed_propagation_lock #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_bit    (key_bit),
        .key_ready  (key_ready),
        .key_reload (key_reload),
        .key_done   (key_done),
        .key_err    (key_err),
        .in_valid   (in_valid),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .out_valid  (out_valid),
        .out1       (out1),
        .out2       (out2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference datapath: returns {out2, out1}.
    function automatic logic [2*WIDTH-1:0] model(input logic [KEY_W-1:0] k,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] k0, k1, k2, w2;
        k0 = k[WIDTH-1:0];
        k1 = k[2*WIDTH-1:WIDTH];
        k2 = k[3*WIDTH-1:2*WIDTH];
        w2 = ~b ^ k1;
        return {(w2 & c) & k2, (a & w2) & k0};
    endfunction

    // One clock, then sample 1 time unit after the edge and run the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cycle++;
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("latency", cycle, e.due);
                check("out1", 32'(out1), 32'(e.o1));
                check("out2", 32'(out2), 32'(e.o2));
                last1 = e.o1;
                last2 = e.o2;
            end
        end else begin
            check("out1_hold", 32'(out1), 32'(last1));
            check("out2_hold", 32'(out2), 32'(last2));
            if (q.size() > 0 && q[0].due <= cycle) begin
                check("out_valid_missing", 32'(out_valid), 32'd1);
                void'(q.pop_front());
            end
        end
    endtask

    task automatic send_data(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] c);
        logic [2*WIDTH-1:0] r;
        in1 = a; in2 = b; in3 = c; in_valid = 1'b1;
        r = model(model_key, a, b, c);
        q.push_back('{due: cycle + 2, o1: r[WIDTH-1:0], o2: r[2*WIDTH-1:WIDTH]});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 10 && q.size() > 0; n++) tick();
        check("drain_queue_empty", q.size(), 0);
    endtask

    // Shift a key in LSB first; with parity enabled, follow with bit par.
    task automatic send_key(input logic [KEY_W-1:0] k, input logic par);
        for (int i = 0; i < KEY_W; i++) begin
            check("key_ready_in_load", 32'(key_ready), 32'd1);
            check("key_done_early", 32'(key_done), 32'd0);
            key_valid = 1'b1;
            key_bit   = k[i];
            tick();
        end
`ifdef KEY_PARITY_EN
        check("key_done_before_parity", 32'(key_done), 32'd0);
        check("key_ready_in_parity", 32'(key_ready), 32'd1);
        key_valid = 1'b1;
        key_bit   = par;
        tick();
`else
        if (par === 1'bx) $display("note: parity bit unused");
`endif
        key_valid = 1'b0;
        key_bit   = 1'b0;
    endtask

    initial begin
        logic [KEY_W-1:0] good_key;
        logic [KEY_W-1:0] bad_key;
        good_key = 12'hF0F;   // k0=F, k1=0, k2=F
        bad_key  = 12'hFFF;   // k1=F

        rst = 1'b1; key_valid = 1'b0; key_bit = 1'b0; key_reload = 1'b0;
        in_valid = 1'b0; in1 = '0; in2 = '0; in3 = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_key_ready", 32'(key_ready), 32'd1);
        check("rst_key_done", 32'(key_done), 32'd0);
        check("rst_key_err", 32'(key_err), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);

        // No key loaded: results forced to zero
        send_data(4'hC, 4'h5, 4'h3);
        drain();

        // Correct key, then back-to-back samples
        send_key(good_key, ^good_key);
        model_key = good_key;
        check("armed_key_done", 32'(key_done), 32'd1);
        check("armed_key_ready", 32'(key_ready), 32'd0);
        check("armed_key_err", 32'(key_err), 32'd0);
        send_data(4'hC, 4'h5, 4'h3);
        send_data(4'hF, 4'h0, 4'hF);
        send_data(4'h6, 4'h9, 4'hA);
        tick();
        send_data(4'h3, 4'hA, 4'hC);
        drain();

        // Reload with a simultaneous key bit: bit must be discarded
        key_reload = 1'b1; key_valid = 1'b1; key_bit = 1'b1;
        model_key = '0;
        tick();
        key_reload = 1'b0; key_valid = 1'b0; key_bit = 1'b0;
        check("reload_key_done", 32'(key_done), 32'd0);
        check("reload_key_ready", 32'(key_ready), 32'd1);

        // Wrong key (k1=F): only arms after exactly KEY_W fresh bits
        send_key(bad_key, ^bad_key);
        model_key = bad_key;
        check("bad_key_done", 32'(key_done), 32'd1);
        send_data(4'hC, 4'h5, 4'h3);
        drain();

        // Sample in flight while leaving ARMED sees the zero key
        model_key = '0;
        key_reload = 1'b1;
        send_data(4'hC, 4'h5, 4'h3);
        key_reload = 1'b0;
        drain();
        check("inflight_key_done", 32'(key_done), 32'd0);

        // Reset after 7 key bits discards them
        for (int i = 0; i < 7; i++) begin
            key_valid = 1'b1;
            key_bit   = good_key[i];
            tick();
        end
        rst = 1'b1;
        last1 = '0;
        last2 = '0;
        tick();
        rst = 1'b0; key_valid = 1'b0;
        check("midload_rst_done", 32'(key_done), 32'd0);
        check("midload_rst_ready", 32'(key_ready), 32'd1);
        send_key(good_key, ^good_key);
        model_key = good_key;
        check("reload_after_rst_done", 32'(key_done), 32'd1);
        send_data(4'hC, 4'h5, 4'h3);
        drain();

`ifdef KEY_PARITY_EN
        // Wrong parity -> ERR with zero key, then recover via reload
        key_reload = 1'b1;
        tick();
        key_reload = 1'b0;
        model_key = '0;
        send_key(good_key, ~(^good_key));
        check("err_key_err", 32'(key_err), 32'd1);
        check("err_key_done", 32'(key_done), 32'd0);
        check("err_key_ready", 32'(key_ready), 32'd0);
        send_data(4'hC, 4'h5, 4'h3);
        drain();
        key_reload = 1'b1;
        tick();
        key_reload = 1'b0;
        check("err_cleared", 32'(key_err), 32'd0);
        send_key(good_key, ^good_key);
        model_key = good_key;
        check("parity_ok_done", 32'(key_done), 32'd1);
        send_data(4'hC, 4'h5, 4'h3);
        drain();
`else
        check("key_err_tied", 32'(key_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
